seq_alu: RTL and testbench

- Parametrised, clocked successor to the team's combinational ALU.
- Adds registered operands, a valid/ready handshake on both sides, and status flags.
- Multiply, divide and modulo are multi-cycle iterative units; all other ops complete in one cycle.
- Sits between the instruction/ROM fetch stage and the result writeback stage.

---
 rtl/seq_alu.sv | 231 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu - clocked ALU with valid/ready handshakes and status flags.
//
// Sits between the fetch stage (command side) and the writeback stage
// (result side). Single-cycle ops finish on the accept edge. mul, div and mod
// run one iteration per clock for BITS clocks.
//
// Handshake rule, both sides: a transfer happens on a rising clk edge where
// valid && ready are both 1. The producer holds valid and its payload stable
// until that edge. The command side is ready only in IDLE, and commands are
// never queued. The result side is valid only in DONE, where out and the
// flags stay frozen until the transfer.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   command (op, inp1, inp2) presented
//   in_ready   block can accept a command (state == IDLE)
//   op         operation select
//   inp1/inp2  operands A / B
//   out_valid  result and flags valid (state == DONE)
//   out_ready  consumer accepts the result
//   out        result (BITS wide, truncated)
//   carry      carry / borrow / mul-overflow / last bit shifted out
//   zero       out == 0
//   div_zero   div or mod by zero occurred
//   busy       state != IDLE
//   dbg_state  raw FSM state (0 IDLE, 1 EXEC, 2 DONE)
// ----------------------------------------------------------------------------
module seq_alu #(
    parameter int BITS = 8,
    parameter int OP   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP-1:0]   op,
    input  logic [BITS-1:0] inp1,
    input  logic [BITS-1:0] inp2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out,
    output logic            carry,
    output logic            zero,
    output logic            div_zero,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    localparam int SH_W  = $clog2(BITS);
    localparam int CNT_W = $clog2(BITS + 1);

    localparam logic [OP-1:0] OP_SUB  = OP'(1);
    localparam logic [OP-1:0] OP_MUL  = OP'(2);
    localparam logic [OP-1:0] OP_DIV  = OP'(3);
    localparam logic [OP-1:0] OP_MOD  = OP'(4);
    localparam logic [OP-1:0] OP_XOR  = OP'(5);
    localparam logic [OP-1:0] OP_NOR  = OP'(6);
    localparam logic [OP-1:0] OP_XNOR = OP'(7);
    localparam logic [OP-1:0] OP_SHL  = OP'(8);
    localparam logic [OP-1:0] OP_SHR  = OP'(9);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OP-1:0]   op_q, op_d;
    // lo_q: latched inp1, then the multiplier/product-low or dividend/quotient.
    // hi_q: product-high for mul, partial remainder for div/mod.
    logic [BITS-1:0] lo_q, lo_d;
    logic [BITS-1:0] hi_q, hi_d;
    logic [BITS-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] out_q, out_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            div_zero_q, div_zero_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath, fed straight from the inputs on the accept edge
    // ------------------------------------------------------------------
    logic [BITS:0]   sum_w, diff_w, shl_w, shr_w;
    logic [SH_W-1:0] sh;
    logic [BITS-1:0] sc_out;
    logic            sc_carry;
    logic            is_iter;

    always_comb begin
        sh       = inp2[SH_W-1:0];
        sum_w    = {1'b0, inp1} + {1'b0, inp2};
        // Top bit of the widened difference is the borrow (inp1 < inp2).
        diff_w   = {1'b0, inp1} - {1'b0, inp2};
        // One guard bit catches the last bit shifted out; it is 0 for shift 0.
        shl_w    = {1'b0, inp1} << sh;
        shr_w    = {inp1, 1'b0} >> sh;
        sc_out   = sum_w[BITS-1:0];
        sc_carry = sum_w[BITS];
        case (op)
            OP_SUB:  begin sc_out = diff_w[BITS-1:0]; sc_carry = diff_w[BITS]; end
            OP_XOR:  begin sc_out = inp1 ^ inp2;      sc_carry = 1'b0; end
            OP_NOR:  begin sc_out = ~(inp1 | inp2);   sc_carry = 1'b0; end
            OP_XNOR: begin sc_out = ~(inp1 ^ inp2);   sc_carry = 1'b0; end
            OP_SHL:  begin sc_out = shl_w[BITS-1:0];  sc_carry = shl_w[BITS]; end
            OP_SHR:  begin sc_out = shr_w[BITS:1];    sc_carry = shr_w[0]; end
            default: ;  // add, including every unassigned opcode
        endcase
        is_iter = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring division
    // ------------------------------------------------------------------
    logic [BITS:0]   mul_sum, div_sh;
    logic [BITS-1:0] div_sub, hi_n, lo_n;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh  = {hi_q, lo_q[BITS-1]};
        // Only used when div_sh >= b_q, so the true difference fits BITS bits.
        div_sub = div_sh[BITS-1:0] - b_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        if (op_q == OP_MUL) begin
            hi_n = mul_sum[BITS:1];
            lo_n = {mul_sum[0], lo_q[BITS-1:1]};
        end else if (div_sh >= {1'b0, b_q}) begin
            // With b_q == 0 this branch is always taken, which gives
            // quotient = all ones and remainder = dividend.
            hi_n = div_sub;
            lo_n = {lo_q[BITS-2:0], 1'b1};
        end else begin
            hi_n = div_sh[BITS-1:0];
            lo_n = {lo_q[BITS-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and register updates
    // ------------------------------------------------------------------
    logic [BITS-1:0] iter_out;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        div_zero_d = div_zero_q;
        iter_out   = (op_q == OP_MOD) ? hi_n : lo_n;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    lo_d  = inp1;
                    b_d   = inp2;
                    hi_d  = '0;
                    cnt_d = '0;
                    if (is_iter) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d    = S_DONE;
                        out_d      = sc_out;
                        carry_d    = sc_carry;
                        zero_d     = (sc_out == '0);
                        div_zero_d = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BITS - 1)) begin
                    state_d    = S_DONE;
                    out_d      = iter_out;
                    zero_d     = (iter_out == '0);
                    carry_d    = (op_q == OP_MUL) && (hi_n != '0);
                    div_zero_d = (op_q != OP_MUL) && (b_q == '0);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out       = out_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign div_zero  = div_zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu - self-checking bench for seq_alu (BITS=8, OP=4).
// Expected {div_zero, zero, carry, out} words go into exp_q when a command is
// accepted and are popped when the result is presented.
// ----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W  = 8;
    localparam int EW = W + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] inp1, inp2, out;
    logic         carry, zero, div_zero, busy;
    logic [1:0]   dbg_state;

    seq_alu #(.BITS(W), .OP(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .inp1(inp1), .inp2(inp2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .zero(zero), .div_zero(div_zero),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pk(input logic dz, input logic z, input logic c,
                                          input logic [W-1:0] o);
        return {dz, z, c, o};
    endfunction

    // Reference model written from the operation definitions.
    function automatic logic [EW-1:0] model(input int opc, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] o;
        logic c, dz;
        int s, sh;
        c  = 1'b0;
        dz = 1'b0;
        sh = int'(b[2:0]);
        case (opc)
            1: begin o = a - b; c = (a < b); end
            2: begin s = int'(a) * int'(b); o = s[W-1:0]; c = (s > 255); end
            3: if (b == 0) begin o = 8'hff; dz = 1'b1; end else o = a / b;
            4: if (b == 0) begin o = a; dz = 1'b1; end else o = a % b;
            5: o = a ^ b;
            6: o = ~(a | b);
            7: o = ~(a ^ b);
            8: begin o = a << sh; c = (sh == 0) ? 1'b0 : a[8 - sh]; end
            9: begin o = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
            default: begin s = int'(a) + int'(b); o = s[W-1:0]; c = (s > 255); end
        endcase
        return pk(dz, (o == 0), c, o);
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_cmd(input int opc, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [EW-1:0] e);
        check("in_ready_before_cmd", in_ready, 1);
        in_valid = 1'b1;
        op       = 4'(opc);
        inp1     = a;
        inp2     = b;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        inp1     = $urandom_range(0, 255);  // operands must not matter now
        inp2     = $urandom_range(0, 255);
    endtask

    task automatic wait_out(input int lat);
        int cyc;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid", out_valid, 1);
        check("latency", cyc, lat);
    endtask

    task automatic check_result();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check("out", out, e[W-1:0]);
            check("carry", carry, e[W]);
            check("zero", zero, e[W+1]);
            check("div_zero", div_zero, e[W+2]);
        end
    endtask

    task automatic complete();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_after_hs", out_valid, 0);
        check("ready_after_hs", in_ready, 1);
    endtask

    task automatic send(input int opc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [EW-1:0] e, input int lat);
        send_cmd(opc, a, b, e);
        wait_out(lat);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_result();
        complete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int ropc, rlat;
        logic [W-1:0] ra, rb;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; inp1 = '0; inp2 = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out", out, 0);
        check("rst_flags", {div_zero, zero, carry}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed
        send(0, 8'd200, 8'd100, pk(0, 0, 1, 8'd44), 1);
        send(1, 8'd5,   8'd7,   pk(0, 0, 1, 8'd254), 1);
        send(2, 8'd15,  8'd17,  pk(0, 0, 0, 8'd255), 9);
        send(2, 8'd16,  8'd16,  pk(0, 1, 1, 8'd0), 9);
        send(3, 8'd100, 8'd7,   pk(0, 0, 0, 8'd14), 9);
        send(4, 8'd100, 8'd7,   pk(0, 0, 0, 8'd2), 9);
        send(3, 8'd55,  8'd0,   pk(1, 0, 0, 8'd255), 9);
        send(4, 8'd55,  8'd0,   pk(1, 0, 0, 8'd55), 9);
        send(8, 8'h81,  8'd1,   pk(0, 0, 1, 8'h02), 1);
        send(9, 8'h81,  8'd1,   pk(0, 0, 1, 8'h40), 1);
        send(12, 8'd3,  8'd4,   pk(0, 0, 0, 8'd7), 1);

        // Backpressure: new command held on the inputs while the result waits
        send_cmd(0, 8'd10, 8'd20, pk(0, 0, 0, 8'd30));
        wait_out(1);
        check_result();
        in_valid = 1'b1; op = 4'd0; inp1 = 8'd50; inp2 = 8'd60;
        repeat (5) begin
            @(negedge clk);
            check("bp_out", out, 30);
            check("bp_flags", {div_zero, zero, carry}, 0);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ready_back", in_ready, 1);
        check("bp_valid_drop", out_valid, 0);
        @(posedge clk);
        exp_q.push_back(pk(0, 0, 0, 8'd110));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_new_valid", out_valid, 1);
        check_result();
        complete();

        // Reset in the middle of a multiply
        send_cmd(2, 8'd200, 8'd3, model(2, 8'd200, 8'd3));
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_flags", {div_zero, zero, carry}, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(0, 8'd1, 8'd1, pk(0, 0, 0, 8'd2), 1);

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            ropc = $urandom_range(0, 15);
            ra   = 8'($urandom_range(0, 255));
            rb   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            rlat = (ropc >= 2 && ropc <= 4) ? 9 : 1;
            send(ropc, ra, rb, model(ropc, ra, rb), rlat);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
